serial_subtractor: RTL



---
 rtl/serial_sub_pkg.sv | 16 +
 rtl/serial_subtractor_fs.sv | 14 +
 rtl/serial_subtractor.sv | 139 +++++++++++++
 3 files changed

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the bit-counter width helper.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Counter wide enough to hold WIDTH-1 without wrapping, with one bit spare.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_fs.sv
// Combinational full-subtractor cell: d = x - y - bin, with borrow out.
// Mirror of the adder datapath's full-adder cell.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial, LSB-first unsigned subtractor: diff = a - b, bout = (a < b).
// One full-subtractor slice is iterated over WIDTH clock edges.
// Optional feature macro: SERIAL_SUB_OVF_EN adds a registered signed
// overflow output 'ovf' held alongside diff.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = cnt_width(WIDTH);

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_dsh;
    logic             r_borrow;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;

    logic             w_d;
    logic             w_bout;
    logic             w_last;
    logic             w_accept;
    logic [WIDTH-1:0] w_dsh_next;

`ifdef SERIAL_SUB_OVF_EN
    logic             r_sa;
    logic             r_sb;
    logic             r_ovf;
`endif

    full_subtractor u_fs (
        .x    (r_a[0]),
        .y    (r_b[0]),
        .bin  (r_borrow),
        .d    (w_d),
        .bout (w_bout)
    );

    // New difference bit enters at the MSB; earlier bits move toward the LSB.
    assign w_dsh_next = (r_dsh >> 1) | (WIDTH'(w_d) << (WIDTH - 1));
    assign w_last     = (r_cnt == CW'(WIDTH - 1));
    // start is honoured only when no operation is in flight (IDLE or DONE).
    assign w_accept   = start && ((r_state == IDLE) || (r_state == DONE));

    // Control FSM plus serial datapath; result registers only load on completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_dsh    <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_ovf    <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_state  <= SHIFT;
                r_a      <= a;
                r_b      <= b;
                r_dsh    <= '0;
                r_borrow <= 1'b0;
                r_cnt    <= '0;
                r_busy   <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
                r_sa     <= a[WIDTH-1];
                r_sb     <= b[WIDTH-1];
`endif
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state <= IDLE;
                    end
                    SHIFT: begin
                        r_a      <= r_a >> 1;
                        r_b      <= r_b >> 1;
                        r_borrow <= w_bout;
                        r_dsh    <= w_dsh_next;
                        r_cnt    <= r_cnt + 1'b1;
                        if (w_last) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_diff  <= w_dsh_next;
                            r_bout  <= w_bout;
`ifdef SERIAL_SUB_OVF_EN
                            // Final bit computed this edge is the result's sign.
                            r_ovf   <= (r_sa ^ r_sb) & (w_d ^ r_sa);
`endif
                        end
                    end
                    DONE: begin
                        r_state <= IDLE;
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign diff = r_diff;
    assign bout = r_bout;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf  = r_ovf;
`endif

endmodule
